// File: rtl/id_decode_stage.sv
// Decode stage of the 8-bit RISC-V pipeline: field decode, load-use hazard, ID/EX register.
// Define ID_BYPASS_EN to build the write-through bypass; otherwise write conflicts stall one cycle.
module id_decode_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              if_ready,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_read_reg1,
  output logic [REG_AW-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              stall
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
    logic mem_to_reg;
  } ctrl_t;

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  ctrl_t             ctrl;
  ctrl_t             ex_ctrl_q;
  logic [DATA_W-1:0] imm;
  logic              rs1_used;
  logic              rs2_used;
  logic              load_use;
  logic              wb_conflict;
  logic              issue;
  logic              unused_instr_bits;

  assign opcode       = if_instr[6:0];
  assign rd           = if_instr[11:7];
  assign rs1          = if_instr[19:15];
  assign rs2          = if_instr[24:20];
  assign rf_read_reg1 = rs1;
  assign rf_read_reg2 = rs2;
  assign unused_instr_bits = ^{if_instr[31], if_instr[29:28]};

  always_comb begin
    ctrl     = '0;
    imm      = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = DATA_W'(if_instr[27:20]);
        rs1_used       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        imm             = DATA_W'(if_instr[27:20]);
        rs1_used        = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        imm            = DATA_W'({if_instr[27:25], if_instr[11:7]});
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        imm         = DATA_W'({if_instr[27:25], if_instr[11:8], 1'b0});
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        imm            = DATA_W'({if_instr[27:21], 1'b0});
      end
      default: ;
    endcase
  end

  assign load_use = ex_valid && ex_ctrl_q.mem_read && (ex_rd != '0) && if_valid &&
                    ((rs1_used && (ex_rd == rs1)) || (rs2_used && (ex_rd == rs2)));

`ifdef ID_BYPASS_EN
  assign wb_conflict = 1'b0;
`else
  // Without a bypass, hold one cycle so the read happens after the write lands.
  assign wb_conflict = if_valid && wb_reg_write && (wb_write_reg != '0) &&
                       ((rs1_used && (wb_write_reg == rs1)) || (rs2_used && (wb_write_reg == rs2)));
`endif

  assign stall    = !flush && (load_use || wb_conflict);
  assign if_ready = !stall;
  assign issue    = if_valid && !flush && !stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
    end else if (issue) begin
      ex_valid    <= 1'b1;
      ex_ctrl_q   <= ctrl;
      ex_pc       <= if_pc;
      ex_imm      <= imm;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_rd       <= rd;
      ex_funct3   <= if_instr[14:12];
      ex_funct7b5 <= if_instr[30];
    end else begin
      ex_valid    <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
    end
  end

  assign ex_reg_write  = ex_ctrl_q.reg_write;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_mem_write  = ex_ctrl_q.mem_write;
  assign ex_branch     = ex_ctrl_q.branch;
  assign ex_jump       = ex_ctrl_q.jump;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;

`ifdef ID_BYPASS_EN
  logic              byp1_q;
  logic              byp2_q;
  logic [DATA_W-1:0] byp1_data_q;
  logic [DATA_W-1:0] byp2_data_q;

  // The register file returns the pre-write value when written on the capture edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp1_data_q <= '0;
      byp2_data_q <= '0;
    end else begin
      byp1_q      <= issue && wb_reg_write && (wb_write_reg == rs1) && (rs1 != '0);
      byp2_q      <= issue && wb_reg_write && (wb_write_reg == rs2) && (rs2 != '0);
      byp1_data_q <= wb_write_data;
      byp2_data_q <= wb_write_data;
    end
  end

  assign ex_rs1_data = (ex_rs1 == '0) ? '0 : (byp1_q ? byp1_data_q : rf_read_data1);
  assign ex_rs2_data = (ex_rs2 == '0) ? '0 : (byp2_q ? byp2_data_q : rf_read_data2);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_write_data;

  assign ex_rs1_data = (ex_rs1 == '0) ? '0 : rf_read_data1;
  assign ex_rs2_data = (ex_rs2 == '0) ? '0 : rf_read_data2;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// Table-driven bench for id_decode_stage with a synchronous-read register-file model.
module tb_id_decode_stage;

  logic        clock;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_ready;
  logic        flush;
  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic [7:0]  rf_read_data1, rf_read_data2;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [7:0]  wb_write_data;
  logic        ex_valid;
  logic [7:0]  ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_mem_to_reg;
  logic        stall;

  int checks = 0;
  int errors = 0;

  id_decode_stage dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .flush(flush),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
    .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: synchronous read returning the pre-write value on a same-edge write.
  logic [7:0] rf_mem [32];
  always @(posedge clock) begin
    rf_read_data1 <= rf_mem[rf_read_reg1];
    rf_read_data2 <= rf_mem[rf_read_reg2];
    if (wb_reg_write) rf_mem[wb_write_reg] <= wb_write_data;
  end

  localparam logic [6:0] RW = 7'b1000000, MR = 7'b0100000, MW = 7'b0010000, BR = 7'b0001000,
                         JP = 7'b0000100, AS = 7'b0000010, MT = 7'b0000001;
  localparam logic [6:0] OPC_I = 7'b0010011, OPC_LOAD = 7'b0000011;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  ctrl;
    logic [7:0]  imm;
    logic        chk_imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7b5;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [7:0] exp_data(input logic [4:0] r);
    return (r == 5'd0) ? 8'h00 : init_val(int'(r));
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [7:0] pc,
                               input logic fl, input logic wr, input logic [4:0] wreg,
                               input logic [7:0] wdata);
    if_valid      = v;
    if_instr      = instr;
    if_pc         = pc;
    flush         = fl;
    wb_reg_write  = wr;
    wb_write_reg  = wreg;
    wb_write_data = wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 5'd0, 8'h0);
  endtask

  initial begin
    vecs[0] = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPC_I),         RW|AS,       8'h05, 1'b1, 5'd0,  5'd5,  5'd1,  3'd0, 1'b0};
    vecs[1] = '{enc_i(12'd0, 5'd2, 3'd0, 5'd3, OPC_LOAD),      RW|MR|AS|MT, 8'h00, 1'b1, 5'd2,  5'd0,  5'd3,  3'd0, 1'b0};
    vecs[2] = '{enc_r(7'h20, 5'd1, 5'd3, 3'd0, 5'd4),          RW,          8'h00, 1'b1, 5'd3,  5'd1,  5'd4,  3'd0, 1'b1};
    vecs[3] = '{enc_s(12'h02C, 5'd2, 5'd1, 3'd2),              MW|AS,       8'h2C, 1'b1, 5'd1,  5'd2,  5'd12, 3'd2, 1'b0};
    vecs[4] = '{enc_b(13'h01C, 5'd2, 5'd1, 3'd0),              BR,          8'h1C, 1'b1, 5'd1,  5'd2,  5'd28, 3'd0, 1'b0};
    vecs[5] = '{enc_j(21'h40, 5'd1),                           RW|JP,       8'h40, 1'b1, 5'd0,  5'd0,  5'd1,  3'd0, 1'b0};
    vecs[6] = '{enc_i(12'hFFD, 5'd2, 3'd0, 5'd7, OPC_I),       RW|AS,       8'hFD, 1'b1, 5'd2,  5'd29, 5'd7,  3'd0, 1'b1};
    vecs[7] = '{32'h000120B7,                                  7'b0,        8'h00, 1'b0, 5'd2,  5'd0,  5'd1,  3'd2, 1'b0};
    vecs[8] = '{enc_i(12'h080, 5'd31, 3'd4, 5'd9, OPC_I),      RW|AS,       8'h80, 1'b1, 5'd31, 5'd0,  5'd9,  3'd4, 1'b0};
    vecs[9] = '{enc_r(7'h00, 5'd30, 5'd31, 3'd6, 5'd10),       RW,          8'h00, 1'b1, 5'd31, 5'd30, 5'd10, 3'd6, 1'b0};

    reset = 1'b1;
    idle();
    #12;
    checkOutput("reset_ex_valid", ex_valid, 0);
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_mem_to_reg}, 0);
    checkOutput("reset_fields", {ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd}, 0);
    @(negedge clock);
    reset = 1'b0;
    step();

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, i[4:0], init_val(i));
      step();
    end
    idle();
    step();

    for (int k = 0; k < NV; k++) begin
      applyStimulus(1'b1, vecs[k].instr, 8'(8'h20 + k * 4), 1'b0, 1'b0, 5'd0, 8'h0);
      #2;
      checkOutput("vec_stall", stall, 0);
      checkOutput("vec_if_ready", if_ready, 1);
      checkOutput("vec_rf_addr", {rf_read_reg1, rf_read_reg2}, {vecs[k].rs1, vecs[k].rs2});
      step();
      checkOutput("vec_ex_valid", ex_valid, 1);
      checkOutput("vec_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_mem_to_reg}, vecs[k].ctrl);
      if (vecs[k].chk_imm) checkOutput("vec_imm", ex_imm, vecs[k].imm);
      checkOutput("vec_fields", {ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5},
                  {vecs[k].rs1, vecs[k].rs2, vecs[k].rd, vecs[k].f3, vecs[k].f7b5});
      checkOutput("vec_pc", ex_pc, 8'(8'h20 + k * 4));
      checkOutput("vec_rs1_data", ex_rs1_data, exp_data(vecs[k].rs1));
      checkOutput("vec_rs2_data", ex_rs2_data, exp_data(vecs[k].rs2));
      idle();
      step();
    end

    // Load-use with a simultaneous write of the loaded register.
    applyStimulus(1'b1, vecs[1].instr, 8'h60, 1'b0, 1'b0, 5'd0, 8'h0);
    step();
    applyStimulus(1'b1, enc_r(7'h00, 5'd1, 5'd3, 3'd0, 5'd4), 8'h64, 1'b0, 1'b1, 5'd3, 8'h5C);
    #2;
    checkOutput("lu_stall", stall, 1);
    checkOutput("lu_if_ready", if_ready, 0);
    step();
    checkOutput("lu_bubble_valid", ex_valid, 0);
    checkOutput("lu_bubble_rw", ex_reg_write, 0);
    applyStimulus(1'b1, enc_r(7'h00, 5'd1, 5'd3, 3'd0, 5'd4), 8'h64, 1'b0, 1'b0, 5'd0, 8'h0);
    #2;
    checkOutput("lu_release_stall", stall, 0);
    checkOutput("lu_release_ready", if_ready, 1);
    step();
    checkOutput("lu_issue_valid", ex_valid, 1);
    checkOutput("lu_issue_rs1", ex_rs1, 3);
    checkOutput("lu_issue_rs1_data", ex_rs1_data, 8'h5C);
    checkOutput("lu_issue_rs2_data", ex_rs2_data, init_val(1));
    idle();
    step();

    // Write-through: x5 written with 0x7A while add x6,x5,x5 decodes.
    applyStimulus(1'b1, enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6), 8'h68, 1'b0, 1'b1, 5'd5, 8'h7A);
    #2;
`ifdef ID_BYPASS_EN
    checkOutput("wt_stall", stall, 0);
    step();
`else
    checkOutput("wt_stall", stall, 1);
    step();
    checkOutput("wt_bubble_valid", ex_valid, 0);
    applyStimulus(1'b1, enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6), 8'h68, 1'b0, 1'b0, 5'd0, 8'h0);
    #2;
    checkOutput("wt_release_stall", stall, 0);
    step();
`endif
    checkOutput("wt_valid", ex_valid, 1);
    checkOutput("wt_rs1_data", ex_rs1_data, 8'h7A);
    checkOutput("wt_rs2_data", ex_rs2_data, 8'h7A);
    idle();
    step();

    // x0 write must neither stall nor make x0 readable as non-zero.
    applyStimulus(1'b1, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8), 8'h6C, 1'b0, 1'b1, 5'd0, 8'hFF);
    #2;
    checkOutput("x0_stall", stall, 0);
    step();
    checkOutput("x0_valid", ex_valid, 1);
    checkOutput("x0_data_same_cycle", {ex_rs1_data, ex_rs2_data}, 0);
    applyStimulus(1'b1, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8), 8'h70, 1'b0, 1'b0, 5'd0, 8'h0);
    step();
    checkOutput("x0_data_later", {ex_rs1_data, ex_rs2_data}, 0);
    idle();
    step();

    // Flush arriving together with a load-use condition.
    applyStimulus(1'b1, vecs[1].instr, 8'h74, 1'b0, 1'b0, 5'd0, 8'h0);
    step();
    applyStimulus(1'b1, enc_r(7'h00, 5'd1, 5'd3, 3'd0, 5'd4), 8'h78, 1'b1, 1'b0, 5'd0, 8'h0);
    #2;
    checkOutput("fl_stall", stall, 0);
    checkOutput("fl_if_ready", if_ready, 1);
    step();
    checkOutput("fl_ex_valid", ex_valid, 0);
    checkOutput("fl_ex_rw", ex_reg_write, 0);
    idle();
    step();

    // Asynchronous reset while ID/EX holds a real instruction.
    applyStimulus(1'b1, vecs[3].instr, 8'h44, 1'b0, 1'b0, 5'd0, 8'h0);
    step();
    checkOutput("rst_pre_valid", ex_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_valid", ex_valid, 0);
    checkOutput("rst_async_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_mem_to_reg}, 0);
    checkOutput("rst_async_fields", {ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd}, 0);
    step();
    reset = 1'b0;
    applyStimulus(1'b1, vecs[0].instr, 8'h48, 1'b0, 1'b0, 5'd0, 8'h0);
    step();
    checkOutput("rst_after_valid", ex_valid, 1);
    checkOutput("rst_after_imm", ex_imm, 8'h05);
    checkOutput("rst_after_rw_as", {ex_reg_write, ex_alu_src}, 2'b11);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
